// File: rtl/vga_timing_defs.sv
// ---------------------------------------------------------------------------
// vga_timing_defs
//   Shared 640x480@60 VGA timing constants for the scan controller and the
//   renderers, plus a helper that advances a (column,row) position by one
//   pixel with line and frame wrap.
//   No ports (package).
// ---------------------------------------------------------------------------
package vga_timing_defs;

    localparam logic [9:0] H_VIS  = 10'd640;
    localparam logic [9:0] H_FP   = 10'd16;
    localparam logic [9:0] H_SYNC = 10'd96;
    localparam logic [9:0] H_BP   = 10'd48;
    localparam logic [9:0] H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;   // 800

    localparam logic [9:0] V_VIS  = 10'd480;
    localparam logic [9:0] V_FP   = 10'd10;
    localparam logic [9:0] V_SYNC = 10'd2;
    localparam logic [9:0] V_BP   = 10'd33;
    localparam logic [9:0] V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;   // 525

    // Sync pulse spans [START, END): 656..751 columns, 490..491 rows
    localparam logic [9:0] H_SYNC_START = H_VIS + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [9:0] V_SYNC_START = V_VIS + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [9:0] H_MAX = H_TOT - 10'd1;
    localparam logic [9:0] V_MAX = V_TOT - 10'd1;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
    } scan_pos_t;

    // One pixel step in raster order; the last pixel of the frame wraps to (0,0)
    function automatic scan_pos_t scan_advance(input scan_pos_t p);
        scan_pos_t n;
        n = p;
        if (p.h == H_MAX) begin
            n.h = '0;
            n.v = (p.v == V_MAX) ? '0 : p.v + 10'd1;
        end else begin
            n.h = p.h + 10'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/pix_div_gen.sv
// ---------------------------------------------------------------------------
// pix_div_gen
//   Divides the system clock down to the pixel rate. pix_en is a registered
//   one-clock strobe, first high PIX_DIV cycles after reset release and then
//   every PIX_DIV cycles.
//   Ports:
//     clk     in  system clock
//     rst_n   in  asynchronous active-low reset
//     pix_en  out one-clock pixel strobe
// ---------------------------------------------------------------------------
module pix_div_gen #(
    parameter int unsigned PIX_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en
);

    localparam int unsigned      DW      = $clog2(PIX_DIV);
    localparam logic [DW-1:0]    DIV_MAX = DW'(PIX_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          pix_en_q, pix_en_d;

    always_comb begin
        div_d    = (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
        // Registered terminal count: strobe appears in the cycle after div
        // reaches DIV_MAX, which is cycle PIX_DIV after reset release
        pix_en_d = (div_q == DIV_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
        end
    end

    assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// vga_scan_ctrl
//   640x480@60 VGA scan controller. Produces the pixel strobe, the current
//   scan position (h_cnt,v_cnt), a look-ahead position (ah_cnt,av_cnt) that
//   runs LOOKAHEAD pixels ahead for BRAM addressing, and a registered,
//   blanked {rgb,hsync,vsync} bundle one pixel period behind h/v.
//   Optional feature macro: VGA_FRAME_CNT_EN adds the 16-bit frame_cnt port.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     pixel_in[11:0]      renderer pixel for (h_cnt,v_cnt)
//     h_cnt/v_cnt         current column 0..799 / row 0..524
//     ah_cnt/av_cnt       look-ahead column / row
//     pix_en              one-clock strobe per pixel
//     hsync/vsync         active-low syncs
//     vga_rgb[11:0]       blanked registered pixel
//     frame_tick          one-clock pulse when (h,v) becomes (0,0)
//     frame_cnt[15:0]     frames since reset (VGA_FRAME_CNT_EN only)
// ---------------------------------------------------------------------------
module vga_scan_ctrl
    import vga_timing_defs::*;
#(
    parameter int unsigned PIX_DIV   = 4,
    parameter int unsigned LOOKAHEAD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] pixel_in,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic [9:0]  ah_cnt,
    output logic [9:0]  av_cnt,
    output logic        pix_en,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] vga_rgb,
    output logic        frame_tick
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    // LOOKAHEAD is at most 15, so it never crosses the first line
    localparam logic [9:0] AH_RST = 10'(LOOKAHEAD);

    logic pix_en_w;

    pix_div_gen #(.PIX_DIV(PIX_DIV)) u_pix_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (pix_en_w)
    );

    logic [9:0]  h_q,  h_d,  v_q,  v_d;
    logic [9:0]  ah_q, ah_d, av_q, av_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        frame_tick_q, frame_tick_d;
    logic        visible;
    scan_pos_t   cur_nxt, la_nxt;

    always_comb begin
        cur_nxt = scan_advance('{h: h_q,  v: v_q});
        la_nxt  = scan_advance('{h: ah_q, v: av_q});
        visible = (h_q < H_VIS) && (v_q < V_VIS);

        h_d          = h_q;
        v_d          = v_q;
        ah_d         = ah_q;
        av_d         = av_q;
        rgb_d        = rgb_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        frame_tick_d = 1'b0;

        if (pix_en_w) begin
            // Bundle is taken from the pre-advance position, giving a fixed
            // one-pixel latency relative to h/v
            rgb_d        = visible ? pixel_in : '0;
            hsync_d      = ~((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
            vsync_d      = ~((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
            h_d          = cur_nxt.h;
            v_d          = cur_nxt.v;
            ah_d         = la_nxt.h;
            av_d         = la_nxt.v;
            frame_tick_d = (cur_nxt.h == '0) && (cur_nxt.v == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q          <= '0;
            v_q          <= '0;
            ah_q         <= AH_RST;
            av_q         <= '0;
            rgb_q        <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            ah_q         <= ah_d;
            av_q         <= av_d;
            rgb_q        <= rgb_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Counts alongside frame_tick so frame_cnt changes in the same cycle
    // the tick is seen; wraps naturally at 16 bits
    always_comb begin
        frame_cnt_d = frame_tick_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign h_cnt      = h_q;
    assign v_cnt      = v_q;
    assign ah_cnt     = ah_q;
    assign av_cnt     = av_q;
    assign pix_en     = pix_en_w;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign vga_rgb    = rgb_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
`timescale 1ns/1ps
module tb_vga_scan_ctrl;

    localparam int unsigned PIX_DIV = 4;
    localparam int unsigned LA      = 1;
    localparam int          HT      = 800;
    localparam int          VT      = 525;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] pixel_in = '0;
    logic [9:0]  h_cnt, v_cnt, ah_cnt, av_cnt;
    logic        pix_en, hsync, vsync, frame_tick;
    logic [11:0] vga_rgb;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    vga_scan_ctrl #(.PIX_DIV(PIX_DIV), .LOOKAHEAD(LA)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel_in   (pixel_in),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .ah_cnt     (ah_cnt),
        .av_cnt     (av_cnt),
        .pix_en     (pix_en),
        .hsync      (hsync),
        .vsync      (vsync),
        .vga_rgb    (vga_rgb),
        .frame_tick (frame_tick)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        int          h;
        int          v;
    } bundle_t;

    bundle_t     sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          mh = 0, mv = 0;
    int          cnt_hs_low, cnt_vs_low, cnt_rgb_on, cnt_ft;
    logic [9:0]  f_h, f_v, f_ah, f_av;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] f_fc;
`endif

    // Look-ahead position from a linear raster index
    function automatic int la_h(input int h, input int v);
        int idx;
        idx = (v * HT + h + int'(LA)) % (HT * VT);
        return idx % HT;
    endfunction

    function automatic int la_v(input int h, input int v);
        int idx;
        idx = (v * HT + h + int'(LA)) % (HT * VT);
        return idx / HT;
    endfunction

    task automatic clear_stats();
        cnt_hs_low = 0;
        cnt_vs_low = 0;
        cnt_rgb_on = 0;
        cnt_ft     = 0;
    endtask

    // Waits for a pix_en strobe, checking that the scan position holds and
    // frame_tick stays low meanwhile.
    task automatic wait_pix(output bit ok, output int gap);
        ok  = 1'b0;
        gap = 0;
        for (int i = 0; i < int'(2 * PIX_DIV); i++) begin
            if (pix_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
            n_checks++;
            if ({h_cnt, v_cnt, frame_tick} !== {10'(mh), 10'(mv), 1'b0})
                $display("FAIL hold: h=%0d v=%0d ft=%b, required h=%0d v=%0d ft=0",
                         h_cnt, v_cnt, frame_tick, mh, mv);
            else
                n_pass++;
            gap++;
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL pix_en_timeout: pix_en=%b after %0d cycles, required 1", pix_en, gap);
        end
    endtask

    // Drives n pixel periods. mode 0: 12'hfb7, 1: {2'b0,h}, else random.
    task automatic run_pixels(input int n, input int mode);
        bit          ok;
        int          gap;
        logic [11:0] px;
        bundle_t     e, got;
        for (int i = 0; i < n; i++) begin
            wait_pix(ok, gap);
            if (!ok) return;
            if (i > 0) begin
                n_checks++;
                if (gap + 2 !== int'(PIX_DIV))
                    $display("FAIL pix_period: %0d cycles, required %0d", gap + 2, PIX_DIV);
                else
                    n_pass++;
            end
            n_checks++;
            if ({h_cnt, v_cnt, ah_cnt, av_cnt} !==
                {10'(mh), 10'(mv), 10'(la_h(mh, mv)), 10'(la_v(mh, mv))})
                $display("FAIL scan_pos: h=%0d v=%0d ah=%0d av=%0d, required %0d %0d %0d %0d",
                         h_cnt, v_cnt, ah_cnt, av_cnt, mh, mv, la_h(mh, mv), la_v(mh, mv));
            else
                n_pass++;

            case (mode)
                0:       px = 12'hfb7;
                1:       px = {2'b00, 10'(mh)};
                default: px = 12'($urandom);
            endcase
            pixel_in = px;
            e.rgb = (mh < 640 && mv < 480) ? px : 12'h000;
            e.hs  = !(mh >= 656 && mh < 752);
            e.vs  = !(mv >= 490 && mv < 492);
            e.h   = mh;
            e.v   = mv;
            sb.push_back(e);

            @(negedge clk);
            // Off-strobe pixel changes must not reach the output
            pixel_in = 12'($urandom);
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty: size=0, required >0");
            end else begin
                got = sb.pop_front();
                n_checks++;
                if ({vga_rgb, hsync, vsync} !== {got.rgb, got.hs, got.vs})
                    $display("FAIL bundle h=%0d v=%0d: rgb=%h hs=%b vs=%b, required rgb=%h hs=%b vs=%b",
                             got.h, got.v, vga_rgb, hsync, vsync, got.rgb, got.hs, got.vs);
                else
                    n_pass++;
            end
            if (hsync === 1'b0) cnt_hs_low++;
            if (vsync === 1'b0) cnt_vs_low++;
            if (vga_rgb !== 12'h000) cnt_rgb_on++;
            if (frame_tick === 1'b1) cnt_ft++;

            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) mv = 0;
            end
            n_checks++;
            if ({frame_tick, pix_en} !== {(mh == 0 && mv == 0), 1'b0})
                $display("FAIL tick_after_edge at h=%0d v=%0d: ft=%b pix_en=%b, required ft=%b pix_en=0",
                         mh, mv, frame_tick, pix_en, (mh == 0 && mv == 0));
            else
                n_pass++;
            @(negedge clk);
        end
    endtask

    // Preloads the scan and look-ahead counters between strobes.
    task automatic jump_to(input int h, input int v);
        f_h  = 10'(h);
        f_v  = 10'(v);
        f_ah = 10'(la_h(h, v));
        f_av = 10'(la_v(h, v));
        force dut.h_q  = f_h;
        force dut.v_q  = f_v;
        force dut.ah_q = f_ah;
        force dut.av_q = f_av;
        @(posedge clk);
        #1;
        release dut.h_q;
        release dut.v_q;
        release dut.ah_q;
        release dut.av_q;
        mh = h;
        mv = v;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({h_cnt, v_cnt, ah_cnt, av_cnt} !== {10'd0, 10'd0, 10'(LA), 10'd0})
            $display("FAIL %s_pos: h=%0d v=%0d ah=%0d av=%0d, required 0 0 %0d 0",
                     tag, h_cnt, v_cnt, ah_cnt, av_cnt, LA);
        else
            n_pass++;
        n_checks++;
        if ({pix_en, frame_tick, hsync, vsync, vga_rgb} !== {4'b0011, 12'h000})
            $display("FAIL %s_out: pix_en=%b ft=%b hs=%b vs=%b rgb=%h, required 0 0 1 1 000",
                     tag, pix_en, frame_tick, hsync, vsync, vga_rgb);
        else
            n_pass++;
`ifdef VGA_FRAME_CNT_EN
        n_checks++;
        if (frame_cnt !== 16'd0)
            $display("FAIL %s_frame_cnt: %0d, required 0", tag, frame_cnt);
        else
            n_pass++;
`endif
    endtask

    // Releases reset at a falling edge and locates the first strobe.
    task automatic release_and_sync();
        int first;
        first = -1;
        rst_n = 1'b1;
        for (int c = 1; c <= int'(2 * PIX_DIV); c++) begin
            @(negedge clk);
            if (pix_en === 1'b1) begin
                first = c;
                break;
            end
            n_checks++;
            if ({hsync, vsync, vga_rgb, h_cnt, v_cnt, frame_tick} !==
                {1'b1, 1'b1, 12'h000, 10'd0, 10'd0, 1'b0})
                $display("FAIL idle_before_first_pix c=%0d: hs=%b vs=%b rgb=%h h=%0d v=%0d ft=%b",
                         c, hsync, vsync, vga_rgb, h_cnt, v_cnt, frame_tick);
            else
                n_pass++;
        end
        n_checks++;
        if (first !== int'(PIX_DIV))
            $display("FAIL first_pix_en_cycle: %0d, required %0d", first, PIX_DIV);
        else
            n_pass++;
        mh = 0;
        mv = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        pixel_in = 12'hfff;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        release_and_sync();
        run_pixels(8, 2);
    endtask

    task automatic test_full_line();
        jump_to(0, 0);
        clear_stats();
        run_pixels(800, 0);
        n_checks++;
        if ({cnt_hs_low, cnt_rgb_on, cnt_vs_low} !== {32'sd96, 32'sd640, 32'sd0})
            $display("FAIL line_counts: hs_low=%0d rgb_on=%0d vs_low=%0d, required 96 640 0",
                     cnt_hs_low, cnt_rgb_on, cnt_vs_low);
        else
            n_pass++;
    endtask

    task automatic test_vsync_rows();
        jump_to(0, 489);
        clear_stats();
        run_pixels(4 * 800, 0);
        n_checks++;
        if ({cnt_vs_low, cnt_hs_low, cnt_rgb_on} !== {32'sd1600, 32'sd384, 32'sd0})
            $display("FAIL vsync_counts: vs_low=%0d hs_low=%0d rgb_on=%0d, required 1600 384 0",
                     cnt_vs_low, cnt_hs_low, cnt_rgb_on);
        else
            n_pass++;
    endtask

    task automatic test_visible_edge();
        jump_to(636, 479);
        clear_stats();
        run_pixels(8, 0);
        n_checks++;
        if (cnt_rgb_on !== 4)
            $display("FAIL visible_edge_count: %0d, required 4", cnt_rgb_on);
        else
            n_pass++;
    endtask

    task automatic test_frame_wrap();
        jump_to(795, 524);
        clear_stats();
        run_pixels(10, 2);
        n_checks++;
        if (cnt_ft !== 1)
            $display("FAIL frame_tick_count: %0d, required 1", cnt_ft);
        else
            n_pass++;
    endtask

    task automatic test_latency();
        jump_to(630, 0);
        clear_stats();
        run_pixels(15, 1);
        n_checks++;
        if (cnt_rgb_on !== 10)
            $display("FAIL latency_visible_count: %0d, required 10", cnt_rgb_on);
        else
            n_pass++;
    endtask

    task automatic test_reset_midframe();
        jump_to(298, 200);
        run_pixels(2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (2) @(negedge clk);
        check_reset_values("held_reset");
        release_and_sync();
        run_pixels(6, 2);
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt();
        for (int k = 0; k < 3; k++) begin
            jump_to(798, 524);
            run_pixels(4, 0);
        end
        n_checks++;
        if (frame_cnt !== 16'd3)
            $display("FAIL frame_cnt_three: %0d, required 3", frame_cnt);
        else
            n_pass++;
        f_fc = 16'hffff;
        force dut.frame_cnt_q = f_fc;
        @(posedge clk);
        #1;
        release dut.frame_cnt_q;
        jump_to(798, 524);
        run_pixels(4, 0);
        n_checks++;
        if (frame_cnt !== 16'd0)
            $display("FAIL frame_cnt_wrap: %0d, required 0", frame_cnt);
        else
            n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_full_line();
        test_vsync_rows();
        test_visible_edge();
        test_frame_wrap();
        test_latency();
        test_reset_midframe();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
